spi_write_master: RTL and testbench



---
 rtl/spi_write_master.sv | 166 ++++++++++++++++
 tb/tb_spi_write_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_master.sv
// ---------------------------------------------------------------------------
// spi_write_master
//
// Host-side SPI write master. Takes one (ADDR, DATA) pair through a REQ/READY
// handshake and sends it as a mode-0, MSB-first, 16-bit frame
// {ADDR[7:0], DATA[7:0]} on CS/SCLK/SDATA. The rising edge of CS at the end
// of the frame commits the write in the downstream register file.
//
// Frame timing, measured in CLK cycles from the acceptance edge (D = CLK_DIV):
//   0        CS falls, SDATA = ADDR[7]
//   (2k+1)D  SCLK rises for frame bit k (k = 0..15)
//   (2k+2)D  SCLK falls, SDATA moves to the next bit
//   33D      CS rises, DONE pulses for one cycle
//   34D      READY rises, or the next frame starts if REQ is already high
//
// Parameters:
//   CLK_DIV  SCLK half-period in CLK cycles (1..255)
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   REQ    in   write request, taken on an edge where REQ=1 and READY=1
//   ADDR   in   [7:0] register address, sampled at acceptance
//   DATA   in   [7:0] write data, sampled at acceptance
//   READY  out  idle and able to accept REQ
//   DONE   out  one-cycle pulse when CS returns high at frame end
//   CS     out  chip select, active-low, idle high
//   SCLK   out  serial clock, idle low
//   SDATA  out  serial data, changes only while SCLK is low, 0 outside frames
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module spi_write_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic [7:0] ADDR,
    input  logic [7:0] DATA,
    output logic       READY,
    output logic       DONE,
    output logic       CS,
    output logic       SCLK,
    output logic       SDATA
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  div_cnt, div_cnt_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] shreg, shreg_n;
    logic        ready_n, done_n, cs_n, sclk_n;
    logic        div_end;
    logic        accept;

    assign div_end = (div_cnt == DIV_LAST);

    // The shift register's top bit is the SDATA flop. It is loaded at
    // acceptance and cleared on leaving SHIFT, so SDATA idles at 0.
    assign SDATA = shreg[15];

    // A request is taken in IDLE, or directly at the end of GAP so that a
    // held REQ starts the next frame on the same edge READY would have risen.
    assign accept = REQ && ((state == IDLE) || (state == GAP && div_end));

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_end ? 8'd0 : div_cnt + 8'd1;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ready_n   = READY;
        done_n    = 1'b0;
        cs_n      = CS;
        sclk_n    = SCLK;

        case (state)
            IDLE: begin
                div_cnt_n = 8'd0;
            end

            SHIFT: begin
                if (div_end) begin
                    if (!SCLK) begin
                        sclk_n = 1'b1;
                    end else begin
                        // End of a high half: SCLK falls and SDATA advances
                        // on the same edge, keeping SDATA stable around rises.
                        sclk_n = 1'b0;
                        if (bit_cnt == 4'd0) begin
                            state_n = HOLD;
                            shreg_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt - 4'd1;
                            shreg_n   = {shreg[14:0], 1'b0};
                        end
                    end
                end
            end

            HOLD: begin
                if (div_end) begin
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = GAP;
                end
            end

            GAP: begin
                if (div_end) begin
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (accept) begin
            state_n   = SHIFT;
            ready_n   = 1'b0;
            cs_n      = 1'b0;
            sclk_n    = 1'b0;
            div_cnt_n = 8'd0;
            bit_cnt_n = 4'd15;
            shreg_n   = {ADDR, DATA};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
            READY   <= 1'b1;
            DONE    <= 1'b0;
            CS      <= 1'b1;
            SCLK    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            READY   <= ready_n;
            DONE    <= done_n;
            CS      <= cs_n;
            SCLK    <= sclk_n;
        end
    end

endmodule

// File: tb/tb_spi_write_master.sv
// ---------------------------------------------------------------------------
// tb_spi_write_master
//
// Two instances: lane 0 with CLK_DIV=4, lane 1 with CLK_DIV=1. Stimulus pushes
// the expected frame for each issued write into exp_q; a monitor watches both
// lanes, reassembles the bits sampled on SCLK rises, times every edge relative
// to CS falling and pops/compares on each DONE pulse.
// ---------------------------------------------------------------------------
module tb_spi_write_master;

    typedef struct {
        int          lane;
        logic [15:0] frame;
    } exp_t;

    logic            clk = 1'b0;
    logic [1:0]      rst_v;
    logic [1:0]      req_v;
    logic [1:0][7:0] addr_v;
    logic [1:0][7:0] data_v;
    logic [1:0]      ready_v, done_v, cs_v, sclk_v, sdata_v;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_write_master #(.CLK_DIV(4)) dut0 (
        .CLK(clk), .RST(rst_v[0]), .REQ(req_v[0]), .ADDR(addr_v[0]), .DATA(data_v[0]),
        .READY(ready_v[0]), .DONE(done_v[0]), .CS(cs_v[0]), .SCLK(sclk_v[0]), .SDATA(sdata_v[0])
    );

    spi_write_master #(.CLK_DIV(1)) dut1 (
        .CLK(clk), .RST(rst_v[1]), .REQ(req_v[1]), .ADDR(addr_v[1]), .DATA(data_v[1]),
        .READY(ready_v[1]), .DONE(done_v[1]), .CS(cs_v[1]), .SCLK(sclk_v[1]), .SDATA(sdata_v[1])
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int l);
        return (l == 0) ? 4 : 1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          start_c[2]    = '{0, 0};
    int          nbits[2]      = '{0, 0};
    logic [15:0] bits[2]       = '{16'h0, 16'h0};
    bit          in_frame[2]   = '{1'b0, 1'b0};
    bit          wait_rdy[2]   = '{1'b0, 1'b0};
    logic        prev_cs[2]    = '{1'b1, 1'b1};
    logic        prev_sclk[2]  = '{1'b0, 1'b0};
    logic        prev_ready[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        exp_t e;
        int   d;
        for (int l = 0; l < 2; l++) begin
            d = div_of(l);
            if (rst_v[l]) begin
                in_frame[l] = 1'b0;
                wait_rdy[l] = 1'b0;
            end else begin
                if (prev_cs[l] && !cs_v[l]) begin
                    if (wait_rdy[l]) begin
                        check("next_accept_cycle", cyc - start_c[l], 34 * d);
                        wait_rdy[l] = 1'b0;
                    end
                    in_frame[l] = 1'b1;
                    start_c[l]  = cyc;
                    nbits[l]    = 0;
                    bits[l]     = 16'h0;
                end
                if (!prev_ready[l] && ready_v[l] && wait_rdy[l]) begin
                    check("ready_rise_cycle", cyc - start_c[l], 34 * d);
                    wait_rdy[l] = 1'b0;
                end
                if (!prev_sclk[l] && sclk_v[l]) begin
                    check("sclk_rise_in_frame", int'(in_frame[l]), 1);
                    if (in_frame[l]) begin
                        check("sclk_rise_cycle", cyc - start_c[l], (2 * nbits[l] + 1) * d);
                        bits[l] = {bits[l][14:0], sdata_v[l]};
                        nbits[l]++;
                    end
                end
                if (!prev_cs[l] && cs_v[l])
                    check("cs_rise_with_done", int'(done_v[l]), 1);
                if (done_v[l]) begin
                    check("done_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("done_lane", l, e.lane);
                        check("frame_bits", int'(bits[l]), int'(e.frame));
                        check("sclk_rise_count", nbits[l], 16);
                        check("done_cycle", cyc - start_c[l], 33 * d);
                        check("cs_high_at_done", int'(cs_v[l]), 1);
                    end
                    in_frame[l] = 1'b0;
                    wait_rdy[l] = 1'b1;
                end
            end
            prev_cs[l]    = cs_v[l];
            prev_sclk[l]  = sclk_v[l];
            prev_ready[l] = ready_v[l];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input int l);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (ready_v[l]) ok = 1'b1;
            else @(negedge clk);
        end
        check("ready_wait", int'(ok), 1);
    endtask

    task automatic issue(input int l, input logic [7:0] a, input logic [7:0] dt, input bit push);
        exp_t e;
        wait_ready(l);
        addr_v[l] = a;
        data_v[l] = dt;
        req_v[l]  = 1'b1;
        if (push) begin
            e.lane  = l;
            e.frame = {a, dt};
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_v[l] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int l, input string tag);
        check({tag, "_ready"}, int'(ready_v[l]), 1);
        check({tag, "_done"},  int'(done_v[l]),  0);
        check({tag, "_cs"},    int'(cs_v[l]),    1);
        check({tag, "_sclk"},  int'(sclk_v[l]),  0);
        check({tag, "_sdata"}, int'(sdata_v[l]), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;
        bit   ok;
        rst_v  = 2'b11;
        req_v  = 2'b00;
        addr_v = '0;
        data_v = '0;
        #1;
        check_reset_outputs(0, "rst_initial");
        repeat (3) @(negedge clk);
        rst_v = 2'b00;

        // Reset while idle takes effect before any clock edge.
        repeat (2) @(negedge clk);
        #2 rst_v[0] = 1'b1;
        #1 check_reset_outputs(0, "rst_idle");
        @(negedge clk);
        rst_v[0] = 1'b0;
        @(negedge clk);

        // Single write: rises 4..124, CS/DONE at 132, READY at 136.
        issue(0, 8'h01, 8'hA5, 1'b1);
        wait_ready(0);

        // Back-to-back with REQ held high: second accept at 136.
        addr_v[0] = 8'h00;
        data_v[0] = 8'h3C;
        req_v[0]  = 1'b1;
        e.lane = 0; e.frame = 16'h003C; exp_q.push_back(e);
        @(negedge clk);
        addr_v[0] = 8'h01;
        data_v[0] = 8'hC3;
        e.lane = 0; e.frame = 16'h01C3; exp_q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done_v[0]) ok = 1'b1;
        end
        check("b2b_first_done_wait", int'(ok), 1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!cs_v[0]) ok = 1'b1;
        end
        check("b2b_second_accept_wait", int'(ok), 1);
        req_v[0] = 1'b0;
        wait_ready(0);

        // Busy-ignore: REQ pulse with 0xFF/0xFF at cycle 50 of a 0x0055 frame.
        issue(0, 8'h00, 8'h55, 1'b1);
        repeat (48) @(negedge clk);
        addr_v[0] = 8'hFF;
        data_v[0] = 8'hFF;
        req_v[0]  = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        wait_ready(0);
        repeat (40) @(negedge clk);
        check("busy_no_second_frame", int'(cs_v[0]), 1);

        // Abort at cycle 60 (bit 7) for 3 cycles; REQ already high on release.
        issue(0, 8'h00, 8'h55, 1'b0);
        repeat (58) @(negedge clk);
        #2 rst_v[0] = 1'b1;
        #1 check_reset_outputs(0, "rst_shift");
        addr_v[0] = 8'h01;
        data_v[0] = 8'h0F;
        req_v[0]  = 1'b1;
        e.lane = 0; e.frame = 16'h010F; exp_q.push_back(e);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("accept_after_rst_release", int'(cs_v[0]), 0);
        req_v[0] = 1'b0;
        wait_ready(0);

        // Minimum divider on lane 1: rises 1..31, CS at 33, READY at 34.
        issue(1, 8'h00, 8'h81, 1'b1);
        wait_ready(1);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
